// File: rtl/shift_rx_pkg.sv
// Shared types for the serial receive shift register: mode codes and frame FSM states.
package shift_rx_pkg;

   typedef enum logic [2:0] {
      MODE_CLR  = 3'b000,
      MODE_HOLD = 3'b001,
      MODE_SHR  = 3'b010,
      MODE_SHL  = 3'b011,
      MODE_LOAD = 3'b100
   } mode_t;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PARITY  = 1'b1
   } state_t;

endpackage

// File: rtl/shift_rx_bitcnt.sv
// Modulo-WIDTH bit counter; wrap flags the increment that completes a WIDTH-bit word.
module shift_rx_bitcnt
   import shift_rx_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic wrap
);

   localparam int unsigned   CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign wrap = inc && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/shift_rx_frame.sv
// Universal shift register with bit counting, optional trailing parity check and
// a one-cycle frame_valid pulse once a complete word is held in data_out.
module shift_rx_frame
   import shift_rx_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          PARITY_EN  = 1'b1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [2:0]       mode,
   input  logic             serial_in,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] data_out,
   output logic             serial_out,
   output logic             frame_valid,
   output logic             parity_err,
   output logic             data_parity
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             sout_q, sout_d;
   logic             fv_q, fv_d;
   logic             perr_q, perr_d;
   state_t           state_q, state_d;
   logic             cnt_inc, cnt_clr, cnt_wrap;
   mode_t            mode_e;

   shift_rx_bitcnt #(
      .WIDTH(WIDTH)
   ) u_bitcnt (
      .clk (CLK),
      .rst (RST),
      .inc (cnt_inc),
      .clr (cnt_clr),
      .wrap(cnt_wrap)
   );

   assign mode_e = mode_t'(mode);

   always_comb begin
      data_d  = data_q;
      sout_d  = sout_q;
      state_d = state_q;
      fv_d    = 1'b0;
      perr_d  = 1'b0;
      cnt_inc = 1'b0;
      cnt_clr = 1'b0;
      case (mode_e)
         MODE_CLR: begin
            data_d  = '0;
            sout_d  = 1'b0;
            cnt_clr = 1'b1;
            state_d = ST_COLLECT;
         end
         MODE_LOAD: begin
            data_d  = parallel_in;
            cnt_clr = 1'b1;
            state_d = ST_COLLECT;
         end
         MODE_SHR, MODE_SHL: begin
            if (state_q == ST_PARITY) begin
               // The shifted-in bit is the parity bit; data and counter stay put.
               fv_d    = 1'b1;
               perr_d  = ^data_q ^ serial_in ^ PARITY_ODD;
               state_d = ST_COLLECT;
            end else begin
               cnt_inc = 1'b1;
               if (mode_e == MODE_SHR) begin
                  data_d = {serial_in, data_q[WIDTH-1:1]};
                  sout_d = data_q[0];
               end else begin
                  data_d = {data_q[WIDTH-2:0], serial_in};
                  sout_d = data_q[WIDTH-1];
               end
               if (cnt_wrap) begin
                  if (PARITY_EN) begin
                     state_d = ST_PARITY;
                  end else begin
                     fv_d = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         data_q  <= '0;
         sout_q  <= 1'b0;
         fv_q    <= 1'b0;
         perr_q  <= 1'b0;
         state_q <= ST_COLLECT;
      end else begin
         data_q  <= data_d;
         sout_q  <= sout_d;
         fv_q    <= fv_d;
         perr_q  <= perr_d;
         state_q <= state_d;
      end
   end

   assign data_out    = data_q;
   assign serial_out  = sout_q;
   assign frame_valid = fv_q;
   assign parity_err  = perr_q;
   assign data_parity = ^data_q;

endmodule
